// File: rtl/arm_ctrl_pkg.sv
// Shared definitions for the multicycle ARM-style controller: FSM states,
// fault codes, instruction classes and datapath select encodings.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_ERROR
    } state_t;

    localparam logic [1:0] FAULT_NONE        = 2'b00;
    localparam logic [1:0] FAULT_UNDEF_OP    = 2'b01;
    localparam logic [1:0] FAULT_MEM_TIMEOUT = 2'b10;

    localparam logic [1:0] OP_DP    = 2'b00;
    localparam logic [1:0] OP_MEM   = 2'b01;
    localparam logic [1:0] OP_BR    = 2'b10;
    localparam logic [1:0] OP_UNDEF = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // Immediate encodings deliberately equal the Op field of each class.
    localparam logic [1:0] IMM_DP  = OP_DP;
    localparam logic [1:0] IMM_MEM = OP_MEM;
    localparam logic [1:0] IMM_BR  = OP_BR;

    // States in which the controller waits on MemReady and can time out.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/instr_dec.sv
// Instruction-class decode shared by every state: immediate format and
// register-source selects derived purely from Op.
module instr_dec
    import arm_ctrl_pkg::*;
(
    input  logic [1:0] Op,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc
);

    always_comb begin
        case (Op)
            OP_DP:   ImmSrc = IMM_DP;
            OP_MEM:  ImmSrc = IMM_MEM;
            OP_BR:   ImmSrc = IMM_BR;
            default: ImmSrc = OP_UNDEF;
        endcase
        RegSrc = {Op == OP_MEM, Op == OP_BR};
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: state register, MemReady wait/timeout counter,
// sticky fault code and per-state decoding of datapath strobes and selects.
module multicycle_ctrl
    import arm_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       AdrSrc,
    output logic       ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       InstrDone,
    output logic [1:0] FaultCode
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_LIMIT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] fault_q, fault_d;

    // Only the I flag and the L bit steer the sequence.
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    instr_dec u_instr_dec (
        .Op     (Op),
        .ImmSrc (ImmSrc),
        .RegSrc (RegSrc)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = 8'd0;
        fault_d    = fault_q;
        // A ready memory in the limit cycle wins over the timeout.
        if (is_wait_state(state_q) && !MemReady) begin
            if (wait_cnt_q == WAIT_LAST) begin
                state_d = S_ERROR;
                fault_d = FAULT_MEM_TIMEOUT;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                S_FETCH:  state_d = S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_DP:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                        OP_MEM:  state_d = S_MEMADR;
                        OP_BR:   state_d = S_BRANCH;
                        default: begin
                            state_d = S_ERROR;
                            fault_d = FAULT_UNDEF_OP;
                        end
                    endcase
                end
                S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:  state_d = S_MEMWB;
                S_MEMWR:  state_d = S_FETCH;
                S_MEMWB:  state_d = S_FETCH;
                S_ALUWB:  state_d = S_FETCH;
                S_BRANCH: state_d = S_FETCH;
                S_EXECR:  state_d = S_ALUWB;
                S_EXECI:  state_d = S_ALUWB;
                S_ERROR:  state_d = S_ERROR;
                default:  state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= 8'd0;
            fault_q    <= FAULT_NONE;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    assign FaultCode = fault_q;

    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        AdrSrc    = 1'b0;
        ALUOp     = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        InstrDone = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                NextPC    = MemReady;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_MEMADR: ALUSrcB = SRCB_IMM;
            S_EXECI: begin
                ALUSrcB = SRCB_IMM;
                ALUOp   = 1'b1;
            end
            S_EXECR:  ALUOp = 1'b1;
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWR: begin
                AdrSrc    = 1'b1;
                MemW      = 1'b1;
                InstrDone = MemReady;
            end
            S_MEMWB: begin
                RegW      = 1'b1;
                ResultSrc = RES_READDATA;
                InstrDone = 1'b1;
            end
            S_ALUWB: begin
                RegW      = 1'b1;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                Branch    = 1'b1;
                InstrDone = 1'b1;
            end
            default: ;
        endcase
        // Write strobes must never escape while reset is held.
        if (reset) begin
            IRWrite   = 1'b0;
            NextPC    = 1'b0;
            RegW      = 1'b0;
            MemW      = 1'b0;
            Branch    = 1'b0;
            InstrDone = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an instruction-level model.
module tb_multicycle_ctrl;

    localparam int WAIT_LIMIT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'd0;
    logic       MemReady = 1'b0;
    logic       IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, FaultCode;
    logic       InstrDone;

    int  checks = 0;
    int  errors = 0;
    int  retired = 0;
    bit  mon_en = 1'b0;

    multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .MemReady  (MemReady),
        .IRWrite   (IRWrite),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .AdrSrc    (AdrSrc),
        .ALUOp     (ALUOp),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .InstrDone (InstrDone),
        .FaultCode (FaultCode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp, ALUSrcA;
        logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
        logic       InstrDone;
        logic [1:0] FaultCode;
    } outs_t;

    // Model: instruction kind plus cycle index within that instruction.
    localparam logic [2:0] K_NONE = 3'd0, K_ALUR = 3'd1, K_ALUI = 3'd2, K_MEM = 3'd3,
                           K_LOAD = 3'd4, K_STORE = 3'd5, K_BR = 3'd6;

    typedef struct packed {
        logic [2:0] kind;
        logic [2:0] step;
        logic [7:0] wcnt;
        logic       err;
        logic [1:0] fault;
    } model_t;

    model_t m = '0;

    function automatic int instr_len(input logic [2:0] k);
        case (k)
            K_ALUR, K_ALUI, K_STORE: return 4;
            K_LOAD:                  return 5;
            K_BR:                    return 3;
            default:                 return 5;
        endcase
    endfunction

    function automatic model_t model_next(input model_t cur, input logic [1:0] op,
                                          input logic [5:0] funct, input logic mr);
        model_t n = cur;
        bit waiting;
        if (cur.err) return cur;
        waiting = (cur.step == 0) || (cur.step == 3 && (cur.kind == K_LOAD || cur.kind == K_STORE));
        if (waiting && !mr) begin
            if (int'(cur.wcnt) + 1 >= WAIT_LIMIT) begin
                n.err = 1'b1;
                n.fault = 2'b10;
                n.wcnt = 8'd0;
            end else begin
                n.wcnt = cur.wcnt + 8'd1;
            end
            return n;
        end
        n.wcnt = 8'd0;
        if (cur.step == 0) begin
            n.step = 3'd1;
            n.kind = K_NONE;
            return n;
        end
        if (cur.step == 1) begin
            case (op)
                2'b00: n.kind = funct[5] ? K_ALUI : K_ALUR;
                2'b01: n.kind = K_MEM;
                2'b10: n.kind = K_BR;
                default: begin
                    n.err = 1'b1;
                    n.fault = 2'b01;
                    return n;
                end
            endcase
        end
        if (cur.step == 2 && cur.kind == K_MEM) n.kind = funct[0] ? K_LOAD : K_STORE;
        if (int'(cur.step) + 1 >= instr_len(n.kind)) begin
            n.step = 3'd0;
            n.kind = K_NONE;
        end else begin
            n.step = cur.step + 3'd1;
        end
        return n;
    endfunction

    function automatic outs_t model_out(input model_t cur, input logic [1:0] op,
                                        input logic mr, input logic rst);
        outs_t o = '0;
        o.ImmSrc = op;
        o.RegSrc = {op == 2'b01, op == 2'b10};
        o.FaultCode = cur.fault;
        if (!cur.err) begin
            case (cur.step)
                3'd0: begin
                    o.ALUSrcA = 1; o.ALUSrcB = 2'b10; o.ResultSrc = 2'b10;
                    o.IRWrite = mr; o.NextPC = mr;
                end
                3'd1: begin
                    o.ALUSrcA = 1; o.ALUSrcB = 2'b10; o.ResultSrc = 2'b10;
                end
                3'd2: begin
                    if (cur.kind == K_MEM) o.ALUSrcB = 2'b01;
                    if (cur.kind == K_ALUI) begin o.ALUSrcB = 2'b01; o.ALUOp = 1; end
                    if (cur.kind == K_ALUR) o.ALUOp = 1;
                    if (cur.kind == K_BR) begin
                        o.ALUSrcB = 2'b01; o.ResultSrc = 2'b10; o.Branch = 1; o.InstrDone = 1;
                    end
                end
                3'd3: begin
                    if (cur.kind == K_LOAD) o.AdrSrc = 1;
                    if (cur.kind == K_STORE) begin o.AdrSrc = 1; o.MemW = 1; o.InstrDone = mr; end
                    if (cur.kind == K_ALUR || cur.kind == K_ALUI) begin o.RegW = 1; o.InstrDone = 1; end
                end
                3'd4: begin
                    o.RegW = 1; o.ResultSrc = 2'b01; o.InstrDone = 1;
                end
                default: ;
            endcase
        end
        if (rst) begin
            o.IRWrite = 0; o.NextPC = 0; o.RegW = 0; o.MemW = 0; o.Branch = 0; o.InstrDone = 0;
        end
        return o;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= model_next(m, Op, Funct, MemReady);
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        outs_t act, exp;
        if (mon_en) begin
            act = {IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp, ALUSrcA,
                   ALUSrcB, ResultSrc, ImmSrc, RegSrc, InstrDone, FaultCode};
            exp = model_out(m, Op, MemReady, reset);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle_compare t=%0t: got %b required %b", $time, act, exp);
            end
            if (act.InstrDone === 1'b1) begin
                retired++;
                $display("retire #%0d t=%0t Op=%b Funct=%b", retired, $time, Op, Funct);
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] op, input logic [5:0] f, input logic mr);
        @(posedge clk); #1;
        Op = op; Funct = f; MemReady = mr;
        @(negedge clk); #1;
    endtask

    task automatic do_reset(input logic [1:0] op, input logic [5:0] f, input logic mr);
        @(posedge clk); #1;
        MemReady = 1'b1;
        reset = 1'b1;
        mon_en = 1'b1;
        @(negedge clk); #1;
        chk("rst_irwrite", {3'b0, IRWrite}, 4'd0);
        chk("rst_fault", {2'b0, FaultCode}, 4'd0);
        @(posedge clk); #1;
        Op = op; Funct = f; MemReady = mr;
        reset = 1'b0;
        @(negedge clk); #1;
    endtask

    initial begin
        int burst;
        logic [1:0] rop;

        // Data-processing immediate, four cycles.
        do_reset(2'b00, 6'b100000, 1'b1);
        chk("dpi_c1_irwrite", {3'b0, IRWrite}, 4'd1);
        chk("dpi_c1_srcb", {2'b0, ALUSrcB}, 4'b0010);
        cyc(2'b00, 6'b100000, 1'b1);
        chk("dpi_c2_irwrite", {3'b0, IRWrite}, 4'd0);
        cyc(2'b00, 6'b100000, 1'b1);
        chk("dpi_c3_aluop", {3'b0, ALUOp}, 4'd1);
        chk("dpi_c3_srcb", {2'b0, ALUSrcB}, 4'b0001);
        cyc(2'b00, 6'b100000, 1'b1);
        chk("dpi_c4_regw", {3'b0, RegW}, 4'd1);
        chk("dpi_c4_done", {3'b0, InstrDone}, 4'd1);
        chk("dpi_c4_immsrc", {2'b0, ImmSrc}, 4'd0);
        cyc(2'b00, 6'b100000, 1'b1);
        chk("dpi_c5_fetch", {3'b0, IRWrite}, 4'd1);
        $display("scenario data-processing immediate done");

        // Load with three wait cycles in MEMRD.
        cyc(2'b01, 6'b000001, 1'b1);
        cyc(2'b01, 6'b000001, 1'b0);
        chk("ld_memadr_srcb", {2'b0, ALUSrcB}, 4'b0001);
        chk("ld_regsrc", {2'b0, RegSrc}, 4'b0010);
        for (int i = 0; i < 4; i++) begin
            cyc(2'b01, 6'b000001, (i == 3));
            chk("ld_memrd_adrsrc", {3'b0, AdrSrc}, 4'd1);
            chk("ld_memrd_regw", {3'b0, RegW}, 4'd0);
        end
        cyc(2'b01, 6'b000001, 1'b1);
        chk("ld_memwb_regw", {3'b0, RegW}, 4'd1);
        chk("ld_memwb_res", {2'b0, ResultSrc}, 4'b0001);
        cyc(2'b01, 6'b000001, 1'b1);
        $display("scenario load with waits done");

        // Store held through two waits.
        cyc(2'b01, 6'b000000, 1'b1);
        cyc(2'b01, 6'b000000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(2'b01, 6'b000000, (i == 2));
            chk("st_memw", {3'b0, MemW}, 4'd1);
            chk("st_done", {3'b0, InstrDone}, (i == 2) ? 4'd1 : 4'd0);
        end
        cyc(2'b10, 6'b000000, 1'b1);
        chk("st_back_fetch", {3'b0, IRWrite}, 4'd1);
        chk("st_memw_off", {3'b0, MemW}, 4'd0);
        $display("scenario store with waits done");

        // Branch, then undefined op.
        cyc(2'b10, 6'b000000, 1'b1);
        chk("br_immsrc", {2'b0, ImmSrc}, 4'b0010);
        chk("br_regsrc", {2'b0, RegSrc}, 4'b0001);
        cyc(2'b10, 6'b000000, 1'b1);
        chk("br_branch", {3'b0, Branch}, 4'd1);
        chk("br_done", {3'b0, InstrDone}, 4'd1);
        cyc(2'b11, 6'b000000, 1'b1);
        cyc(2'b11, 6'b000000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(2'(i), 6'b100001, 1'b1);
            chk("undef_fault", {2'b0, FaultCode}, 4'b0001);
            chk("undef_irwrite", {3'b0, IRWrite}, 4'd0);
        end
        do_reset(2'b00, 6'b0, 1'b1);
        chk("undef_cleared", {2'b0, FaultCode}, 4'd0);
        $display("scenario branch and undefined op done");

        // Fetch timeout after WAIT_LIMIT low cycles.
        do_reset(2'b00, 6'b0, 1'b0);
        for (int i = 2; i <= WAIT_LIMIT; i++) cyc(2'b00, 6'b0, 1'b0);
        chk("to_not_yet", {2'b0, FaultCode}, 4'd0);
        cyc(2'b00, 6'b0, 1'b1);
        chk("to_fault", {2'b0, FaultCode}, 4'b0010);
        chk("to_irwrite", {3'b0, IRWrite}, 4'd0);
        // Ready on the limit cycle rescues the fetch.
        do_reset(2'b00, 6'b0, 1'b0);
        for (int i = 2; i < WAIT_LIMIT; i++) cyc(2'b00, 6'b0, 1'b0);
        cyc(2'b00, 6'b0, 1'b1);
        chk("rescue_irwrite", {3'b0, IRWrite}, 4'd1);
        cyc(2'b10, 6'b0, 1'b1);
        chk("rescue_fault", {2'b0, FaultCode}, 4'd0);
        chk("rescue_decode", {2'b0, ALUSrcB}, 4'b0010);
        $display("scenario fetch timeout boundary done");

        // Reset in the middle of a store.
        do_reset(2'b01, 6'b0, 1'b1);
        cyc(2'b01, 6'b0, 1'b1);
        cyc(2'b01, 6'b0, 1'b0);
        cyc(2'b01, 6'b0, 1'b0);
        @(posedge clk); #1;
        chk("mid_memw_before", {3'b0, MemW}, 4'd1);
        reset = 1'b1;
        #1;
        chk("mid_memw_drop", {3'b0, MemW}, 4'd0);
        do_reset(2'b00, 6'b0, 1'b1);
        chk("mid_resume_fetch", {3'b0, IRWrite}, 4'd1);
        cyc(2'b00, 6'b0, 1'b1);
        chk("mid_resume_decode", {3'b0, IRWrite}, 4'd0);
        $display("scenario reset mid-store done");

        // Randomized traffic against the model.
        burst = 0;
        for (int i = 0; i < 2500; i++) begin
            if ((m.err && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset(2'($urandom_range(0, 2)), 6'($urandom), 1'($urandom));
            end else begin
                if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(8, 20);
                rop = ($urandom_range(0, 31) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                if (burst > 0) begin
                    burst--;
                    cyc(rop, 6'($urandom), 1'b0);
                end else begin
                    cyc(rop, 6'($urandom), ($urandom_range(0, 9) < 7));
                end
            end
        end
        $display("random phase done, %0d instructions retired", retired);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter: WAIT_LIMIT, 16, consecutive MemReady-low cycles tolerated in a memory state before timeout fault (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: Op  input  2  instruction class, Instr[27:26] from the instruction register.
REQ-005 SHALL have port: Funct  input  6  Instr[25:20]; bit 5 is immediate flag (I), bit 0 is load/store select (L).
REQ-006 SHALL have port: MemReady  input  1  memory has completed the current access this cycle.
REQ-007 SHALL have ports: IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ALUOp  output  1 each  datapath strobes and selects.
REQ-008 SHALL have ports: ALUSrcA  output  1; ALUSrcB, ResultSrc, ImmSrc, RegSrc  output  2 each.
REQ-009 SHALL have ports: InstrDone  output  1  one-cycle pulse on instruction retirement; FaultCode  output  2  00 none, 01 undefined Op, 10 memory timeout.

Function
REQ-010 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, ERROR.
REQ-011 SHALL transition: FETCH->DECODE when MemReady=1, else stay.
REQ-012 SHALL transition from DECODE: Op=01->MEMADR; Op=00,Funct[5]=0->EXECR; Op=00,Funct[5]=1->EXECI; Op=10->BRANCH; Op=11->ERROR with FaultCode=01.
REQ-013 SHALL transition: MEMADR->MEMRD if Funct[0]=1, else MEMWR; MEMRD->MEMWB when MemReady=1; MEMWR->FETCH when MemReady=1; MEMWB, ALUWB, BRANCH->FETCH; EXECR and EXECI->ALUWB.
REQ-014 SHALL hold ERROR with FaultCode fixed until reset; all strobes are 0 in ERROR.
REQ-015 SHALL count consecutive MemReady=0 cycles in FETCH, MEMRD and MEMWR; clear the count on leaving those states or on MemReady=1; on reaching WAIT_LIMIT, enter ERROR with FaultCode=10. MemReady=1 in the limit cycle takes priority.
REQ-016 SHALL drive in FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10; IRWrite=NextPC=MemReady.
REQ-017 SHALL drive in DECODE: ALUSrcA=1, ALUSrcB=10, ALUOp=0, ResultSrc=10.
REQ-018 SHALL drive in MEMADR and EXECI: ALUSrcA=0, ALUSrcB=01; ALUOp=0 in MEMADR and 1 in EXECI. In EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
REQ-019 SHALL drive in MEMRD: AdrSrc=1, ResultSrc=00. In MEMWR: AdrSrc=1, ResultSrc=00, MemW=1 in every cycle until acceptance.
REQ-020 SHALL drive RegW=1 in MEMWB (ResultSrc=01) and ALUWB (ResultSrc=00).
REQ-021 SHALL drive in BRANCH: ALUSrcA=0, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.
REQ-022 SHALL drive all strobes and selects not listed for a state to 0.
REQ-023 SHALL drive ImmSrc=Op and RegSrc={Op==01, Op==10} combinationally in every state.
REQ-024 SHALL pulse InstrDone in the last cycle of MEMWB, ALUWB, BRANCH, and of MEMWR when MemReady=1.
REQ-025 SHALL ignore Op/Funct changes outside DECODE and MEMADR.
REQ-026 SHALL follow a fixed instruction latency with MemReady always 1: data-processing 4 cycles, load 5, store 4, branch 3.

Reset
REQ-027 SHALL enter FETCH immediately on reset assertion, clear the wait counter and set FaultCode=00.
REQ-028 SHALL force IRWrite, NextPC, RegW, MemW, Branch and InstrDone to 0 while reset=1; reset mid-instruction abandons the instruction and causes no write.

Structure
REQ-029 SHALL place in shared package arm_ctrl_pkg: the state enum, FaultCode values, and ALUSrcB, ResultSrc and ImmSrc encodings.
REQ-030 SHALL place the Op-to-ImmSrc/RegSrc logic in one sub-module, instr_dec; state register, wait counter and output decoding stay in multicycle_ctrl.

Verification
REQ-031 SHALL test: Op=00, Funct=6'b100000, MemReady=1 -> FETCH, DECODE, EXECI, ALUWB; RegW=1 in cycle 4; InstrDone pulse in cycle 4; ImmSrc=00.
REQ-032 SHALL test: Op=01, Funct[0]=1, MemReady=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with RegW=1, ResultSrc=01.
REQ-033 SHALL test: Op=01, Funct[0]=0 -> MemW=1 held through waits, single InstrDone on MemReady=1, then FETCH.
REQ-034 SHALL test: Op=10 -> BRANCH with Branch=1, ImmSrc=10, RegSrc=01; and Op=11 -> ERROR, FaultCode=01, sticky until reset.
REQ-035 SHALL test: MemReady=0 for 16 cycles in FETCH -> ERROR, FaultCode=10; MemReady=1 on cycle 16 instead -> DECODE, no fault.
REQ-036 SHALL test: reset asserted mid-MEMWR -> MemW drops the same cycle, and the FSM resumes in FETCH after release.
